// File: rtl/uart_rx.sv
// uart_rx: 8-bit UART receiver, one start bit, LSB-first data, one stop bit.
//
// Optional feature macro: UART_RX_PARITY_EN
//   defined   -> one even-parity bit follows the 8 data bits.
//   undefined -> frame is start + 8 data + stop, and parity_err is tied 0.
//
// Parameters
//   BAUD_RATE  serial bit rate in bits/s
//   CLK_FREQ   clk frequency in Hz (BIT_PERIOD = CLK_FREQ / BAUD_RATE)
//
// Ports
//   clk         system clock, rising edge
//   reset       synchronous active-high reset
//   rx          asynchronous serial input, idle high
//   data        last correctly received byte, held between valid pulses
//   valid       one-cycle pulse when data is updated
//   frame_err   one-cycle pulse on a bad (low) stop bit
//   parity_err  one-cycle pulse on parity mismatch
//   busy        high whenever the receiver is not idle
module uart_rx #(
    parameter int BAUD_RATE = 9600,
    parameter int CLK_FREQ  = 100000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    output logic       frame_err,
    output logic       parity_err,
    output logic       busy
);

    localparam logic [31:0] BIT_PERIOD  = 32'(CLK_FREQ / BAUD_RATE);
    localparam logic [31:0] HALF_PERIOD = BIT_PERIOD / 32'd2;
    localparam logic [31:0] BIT_LAST    = BIT_PERIOD - 32'd1;
    localparam logic [31:0] HALF_LAST   = HALF_PERIOD - 32'd1;

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {
        IDLE, START, DATA, PARITY, STOP, WAIT_HIGH
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE, START, DATA, STOP, WAIT_HIGH
    } state_t;
`endif

    state_t      state, state_next;
    logic        rx_meta, rx_s;
    logic [31:0] cnt, cnt_next;
    logic [2:0]  bit_idx, bit_idx_next;
    logic [7:0]  shift, shift_next;
    logic [7:0]  data_next;
    logic        valid_next, ferr_next;
    logic        par_bad;

`ifdef UART_RX_PARITY_EN
    logic par_bit, par_bit_next;
    logic perr_q, perr_next;

    // Even parity: the received parity bit must equal the XOR of the data bits.
    assign par_bad    = (par_bit != ^shift);
    assign parity_err = perr_q;
`else
    assign par_bad    = 1'b0;
    assign parity_err = 1'b0;
`endif

    assign busy = (state != IDLE);

    // Two-flop synchronizer; both flops reset to the idle (high) level so
    // reset release never looks like a start bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= 32'd0;
            bit_idx   <= 3'd0;
            shift     <= 8'h00;
            data      <= 8'h00;
            valid     <= 1'b0;
            frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bit   <= 1'b0;
            perr_q    <= 1'b0;
`endif
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            bit_idx   <= bit_idx_next;
            shift     <= shift_next;
            data      <= data_next;
            valid     <= valid_next;
            frame_err <= ferr_next;
`ifdef UART_RX_PARITY_EN
            par_bit   <= par_bit_next;
            perr_q    <= perr_next;
`endif
        end
    end

    always_comb begin
        state_next   = state;
        cnt_next     = cnt;
        bit_idx_next = bit_idx;
        shift_next   = shift;
        data_next    = data;
        valid_next   = 1'b0;
        ferr_next    = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bit_next = par_bit;
        perr_next    = 1'b0;
`endif

        case (state)
            IDLE: begin
                cnt_next     = 32'd0;
                bit_idx_next = 3'd0;
                if (!rx_s) state_next = START;
            end

            // Re-check the line at mid start bit so short low glitches are
            // dropped silently; this also centres all later samples.
            START: begin
                if (cnt == HALF_LAST) begin
                    cnt_next = 32'd0;
                    if (!rx_s) begin
                        state_next   = DATA;
                        bit_idx_next = 3'd0;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    cnt_next = cnt + 32'd1;
                end
            end

            DATA: begin
                if (cnt == BIT_LAST) begin
                    cnt_next     = 32'd0;
                    shift_next   = {rx_s, shift[7:1]};
                    bit_idx_next = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_next = PARITY;
`else
                        state_next = STOP;
`endif
                    end
                end else begin
                    cnt_next = cnt + 32'd1;
                end
            end

`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (cnt == BIT_LAST) begin
                    cnt_next     = 32'd0;
                    par_bit_next = rx_s;
                    state_next   = STOP;
                end else begin
                    cnt_next = cnt + 32'd1;
                end
            end
`endif

            STOP: begin
                if (cnt == BIT_LAST) begin
                    cnt_next = 32'd0;
                    if (rx_s) begin
                        state_next = IDLE;
                        if (!par_bad) begin
                            valid_next = 1'b1;
                            data_next  = shift;
                        end
`ifdef UART_RX_PARITY_EN
                        else perr_next = 1'b1;
`endif
                    end else begin
                        // Low stop bit: wait for the line to recover so a
                        // break is not decoded as a stream of 0x00 frames.
                        state_next = WAIT_HIGH;
                        ferr_next  = 1'b1;
`ifdef UART_RX_PARITY_EN
                        perr_next  = par_bad;
`endif
                    end
                end else begin
                    cnt_next = cnt + 32'd1;
                end
            end

            WAIT_HIGH: begin
                cnt_next = 32'd0;
                if (rx_s) state_next = IDLE;
            end

            default: begin
                state_next = IDLE;
                cnt_next   = 32'd0;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at BIT_PERIOD = 16 (1.6 MHz clock, 100 kBd).
// Build with +define+UART_RX_PARITY_EN to add the parity scenario.
module tb_uart_rx;

    localparam int CLK_FREQ  = 1600000;
    localparam int BAUD_RATE = 100000;
    localparam int BP        = 16;
    localparam int HP        = 8;
`ifdef UART_RX_PARITY_EN
    localparam int PBITS = 1;
`else
    localparam int PBITS = 0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       rx = 1'b1;
    logic [7:0] data;
    logic       valid, frame_err, parity_err, busy;

    int tests = 0;
    int fails = 0;

    int         n_valid = 0;
    int         n_ferr  = 0;
    int         n_perr  = 0;
    logic [7:0] vq[$];
    time        valid_t = 0;
    time        start_t = 0;

    uart_rx #(.BAUD_RATE(BAUD_RATE), .CLK_FREQ(CLK_FREQ)) dut (
        .clk       (clk),
        .reset     (reset),
        .rx        (rx),
        .data      (data),
        .valid     (valid),
        .frame_err (frame_err),
        .parity_err(parity_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Pulse monitor, sampling on the falling edge.
    always @(negedge clk) begin
        if (valid) begin
            n_valid++;
            vq.push_back(data);
            valid_t = $time;
        end
        if (frame_err)  n_ferr++;
        if (parity_err) n_perr++;
    end

    task automatic drive(input logic v, input int n);
        rx = v;
        repeat (n) @(posedge clk);
    endtask

    // Full frame; stop level selectable, parity bit given explicitly.
    task automatic send_frame(input logic [7:0] b, input logic stop, input logic par);
        start_t = $time;
        drive(1'b0, BP);
        for (int i = 0; i < 8; i++) drive(b[i], BP);
`ifdef UART_RX_PARITY_EN
        drive(par, BP);
`else
        if (par) rx = 1'b1;
`endif
        drive(stop, BP);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (4) @(posedge clk);
        reset = 1'b0;
        @(negedge clk);
        tests++; if (data !== 8'h00) begin fails++; $display("FAIL reset_data got %h want 00", data); end
        tests++; if (valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b want 0", valid); end
        tests++; if (frame_err !== 1'b0) begin fails++; $display("FAIL reset_ferr got %b want 0", frame_err); end
        tests++; if (parity_err !== 1'b0) begin fails++; $display("FAIL reset_perr got %b want 0", parity_err); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", busy); end
        @(posedge clk);
    endtask

    task automatic test_good_frame();
        int nv, nf, lat;
        nv = n_valid; nf = n_ferr;
        send_frame(8'hA5, 1'b1, 1'b0);
        drive(1'b1, 4);
        lat = int'((valid_t - start_t) / 10);
        tests++; if (n_valid !== nv + 1) begin fails++; $display("FAIL a5_valid_count got %0d want %0d", n_valid - nv, 1); end
        tests++; if (data !== 8'hA5) begin fails++; $display("FAIL a5_data got %h want a5", data); end
        tests++; if (n_ferr !== nf) begin fails++; $display("FAIL a5_ferr got %0d want 0", n_ferr - nf); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL a5_busy got %b want 0", busy); end
        // 2 sync + HALF + 9 bit periods (+1 with parity)
        tests++;
        if (lat < 2 + HP + (9 + PBITS) * BP - 1 || lat > 2 + HP + (9 + PBITS) * BP + 1) begin
            fails++; $display("FAIL a5_latency got %0d want %0d", lat, 2 + HP + (9 + PBITS) * BP);
        end
    endtask

    task automatic test_frame_err();
        int nv, nf;
        nv = n_valid; nf = n_ferr;
        send_frame(8'h3C, 1'b0, 1'b0);
        drive(1'b0, 40 - BP);
        @(negedge clk);
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL ferr_busy_low got %b want 1", busy); end
        tests++; if (n_ferr !== nf + 1) begin fails++; $display("FAIL ferr_count got %0d want 1", n_ferr - nf); end
        @(posedge clk);
        drive(1'b1, 5);
        @(negedge clk);
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL ferr_busy_after got %b want 0", busy); end
        tests++; if (n_valid !== nv) begin fails++; $display("FAIL ferr_valid got %0d want 0", n_valid - nv); end
        tests++; if (data !== 8'hA5) begin fails++; $display("FAIL ferr_data got %h want a5", data); end
        @(posedge clk);
    endtask

    task automatic test_glitch();
        int nv, nf;
        nv = n_valid; nf = n_ferr;
        drive(1'b0, 5);
        @(negedge clk);
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL glitch_busy got %b want 1", busy); end
        @(posedge clk);
        drive(1'b1, 30);
        @(negedge clk);
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL glitch_idle got %b want 0", busy); end
        tests++; if (n_valid !== nv) begin fails++; $display("FAIL glitch_valid got %0d want 0", n_valid - nv); end
        tests++; if (n_ferr !== nf) begin fails++; $display("FAIL glitch_ferr got %0d want 0", n_ferr - nf); end
        tests++; if (data !== 8'hA5) begin fails++; $display("FAIL glitch_data got %h want a5", data); end
        @(posedge clk);
    endtask

    task automatic test_back_to_back();
        int nv;
        nv = n_valid;
        send_frame(8'h00, 1'b1, 1'b0);
        send_frame(8'hFF, 1'b1, 1'b0);
        drive(1'b1, 4);
        tests++;
        if (n_valid !== nv + 2) begin
            fails++; $display("FAIL b2b_count got %0d want 2", n_valid - nv);
        end else begin
            tests++; if (vq[nv] !== 8'h00) begin fails++; $display("FAIL b2b_first got %h want 00", vq[nv]); end
            tests++; if (vq[nv+1] !== 8'hFF) begin fails++; $display("FAIL b2b_second got %h want ff", vq[nv+1]); end
        end
    endtask

    task automatic test_reset_midframe();
        logic [7:0] b;
        int nv;
        b  = 8'h55;
        nv = n_valid;
        drive(1'b0, BP);
        for (int i = 0; i < 4; i++) drive(b[i], BP);
        drive(b[4], HP);
        reset = 1'b1;
        @(posedge clk);
        reset = 1'b0;
        @(negedge clk);
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rst_mid_busy got %b want 0", busy); end
        tests++; if (data !== 8'h00) begin fails++; $display("FAIL rst_mid_data got %h want 00", data); end
        @(posedge clk);
        drive(1'b1, 8 * BP);
        tests++; if (n_valid !== nv) begin fails++; $display("FAIL rst_mid_valid got %0d want 0", n_valid - nv); end
        send_frame(8'h12, 1'b1, 1'b0);
        drive(1'b1, 4);
        tests++; if (n_valid !== nv + 1) begin fails++; $display("FAIL rst_12_count got %0d want 1", n_valid - nv); end
        tests++; if (data !== 8'h12) begin fails++; $display("FAIL rst_12_data got %h want 12", data); end
    endtask

    task automatic test_parity();
`ifdef UART_RX_PARITY_EN
        int nv, np;
        nv = n_valid; np = n_perr;
        send_frame(8'h07, 1'b1, 1'b0);
        drive(1'b1, 4);
        tests++; if (n_perr !== np + 1) begin fails++; $display("FAIL par_bad_perr got %0d want 1", n_perr - np); end
        tests++; if (n_valid !== nv) begin fails++; $display("FAIL par_bad_valid got %0d want 0", n_valid - nv); end
        tests++; if (data !== 8'h12) begin fails++; $display("FAIL par_bad_data got %h want 12", data); end
        send_frame(8'h07, 1'b1, 1'b1);
        drive(1'b1, 4);
        tests++; if (n_valid !== nv + 1) begin fails++; $display("FAIL par_ok_valid got %0d want 1", n_valid - nv); end
        tests++; if (data !== 8'h07) begin fails++; $display("FAIL par_ok_data got %h want 07", data); end
        tests++; if (n_perr !== np + 1) begin fails++; $display("FAIL par_ok_perr got %0d want 1", n_perr - np); end
`else
        tests++; if (n_perr !== 0) begin fails++; $display("FAIL noparity_perr got %0d want 0", n_perr); end
`endif
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_frame_err();
        test_glitch();
        test_back_to_back();
        test_reset_midframe();
        test_parity();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter BAUD_RATE, default 9600, serial bit rate in bits/s.
REQ-002 SHALL have parameter CLK_FREQ, default 100000000, clk frequency in Hz; BIT_PERIOD = CLK_FREQ / BAUD_RATE (integer division), HALF_PERIOD = BIT_PERIOD / 2.
REQ-003 SHALL have port clk, input, 1, system clock; all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port rx, input, 1, asynchronous UART receive line, idle high.
REQ-006 SHALL have port data, output, 8, last correctly received byte.
REQ-007 SHALL have port valid, output, 1, one-cycle pulse when data is updated.
REQ-008 SHALL have port frame_err, output, 1, one-cycle pulse on bad stop bit.
REQ-009 SHALL have port parity_err, output, 1, one-cycle pulse on parity mismatch.
REQ-010 SHALL have port busy, output, 1, high whenever the state is not IDLE.

Function
REQ-011 SHALL pass rx through a two-flop synchronizer, initialized to 1; rx_s denotes the second flop; all decisions use rx_s only.
REQ-012 SHALL implement states IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
REQ-013 IDLE: counter held 0; rx_s == 0 -> START.
REQ-014 START: count to HALF_PERIOD-1; then rx_s == 0 -> DATA with counter 0 and bit index 0; rx_s == 1 -> IDLE (glitch rejected, no output pulse).
REQ-015 DATA: each time counter reaches BIT_PERIOD-1, sample rx_s into the shift register LSB-first, clear counter, increment bit index; after the 8th sample -> PARITY if UART_RX_PARITY_EN is defined, else -> STOP.
REQ-016 PARITY: sample after BIT_PERIOD cycles, store it, -> STOP.
REQ-017 STOP: sample after BIT_PERIOD cycles; rx_s == 1 -> IDLE; rx_s == 0 -> WAIT_HIGH.
REQ-018 WAIT_HIGH: remain until rx_s == 1, then -> IDLE; no start detection while in this state (break condition).
REQ-019 Good stop bit with no parity error: data <= shift register and valid = 1 for exactly one cycle, in the cycle after the stop sample.
REQ-020 Bad stop bit: frame_err = 1 for one cycle; data unchanged; valid stays 0.
REQ-021 Parity error with good stop bit: parity_err = 1 for one cycle; data unchanged; valid stays 0.
REQ-022 Parity error with bad stop bit: both frame_err and parity_err pulse in the same cycle.
REQ-023 data SHALL hold its value between valid pulses; no consumer handshake exists, and a new frame overwrites data without stall.
REQ-024 A new start bit SHALL be accepted in the first cycle after STOP returns to IDLE (back-to-back frames).
REQ-025 Latency from the rx falling edge to the valid pulse SHALL be 2 + HALF_PERIOD + 9*BIT_PERIOD (+BIT_PERIOD with parity) +/-1 cycles.
REQ-026 The counter SHALL be 32 bits wide and SHALL never exceed BIT_PERIOD-1.

Reset
REQ-027 Reset SHALL force state IDLE, counter 0, bit index 0, shift register 0, synchronizer flops 1, data 8'h00, valid 0, frame_err 0, parity_err 0, busy 0.
REQ-028 Reset asserted mid-frame SHALL abort the frame with no pulses; the bench frame remainder SHALL NOT produce valid unless a new falling edge follows reset release.

Configuration
REQ-029 Macro UART_RX_PARITY_EN defined: one even-parity bit follows the 8 data bits; mismatch with XOR of data bits handled per REQ-021/022.
REQ-030 Macro UART_RX_PARITY_EN undefined: PARITY state and parity logic absent; frame is start+8+stop; parity_err tied 0.

Verification (CLK_FREQ=1600000, BAUD_RATE=100000, BIT_PERIOD=16)
REQ-031 Send 8'hA5, stop=1 -> one valid pulse, data=8'hA5, frame_err=0, busy low afterwards.
REQ-032 Send 8'h3C with stop=0, then rx high after 40 cycles -> frame_err pulse, data keeps previous value 8'hA5, no valid, return to IDLE only after rx high.
REQ-033 Low glitch on rx of 5 cycles while idle -> back to IDLE after START, no valid/frame_err, data unchanged.
REQ-034 Back-to-back frames 8'h00 then 8'hFF with zero idle gap -> two valid pulses, data=8'h00 then 8'hFF.
REQ-035 Assert reset for 1 cycle during data bit 4 of 8'h55 -> no valid; busy=0 after reset; subsequent 8'h12 received correctly.
REQ-036 With UART_RX_PARITY_EN, send 8'h07 with parity bit 0 (wrong) -> parity_err pulse, no valid; with parity bit 1 -> valid, data=8'h07.
